// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - windowed error statistics for approximate adders (AEM_BIAS_EN adds bias_sum)
module approx_err_monitor #(
    parameter int N      = 8,
    parameter int WINDOW = 16,
    parameter int CW     = $clog2(WINDOW + 1),
    parameter int SW     = N + 1 + $clog2(WINDOW)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic [N-1:0]         approx_sum,
    input  logic                 approx_fn,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CW-1:0]        err_count,
    output logic [N:0]           max_ed,
`ifdef AEM_BIAS_EN
    output logic [SW-1:0]        sum_ed,
    output logic signed [SW:0]   bias_sum
`else
    output logic [SW-1:0]        sum_ed
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N:0]    exact;
    logic [N:0]    approx;
    logic [N:0]    ed;
    logic          accept;
    logic          clr;
    logic [N:0]    ed_q;
    logic          v1;

    assign exact  = {1'b0, a} + {1'b0, b};
    assign approx = {approx_fn, approx_sum};
    // Compare before subtracting so the distance never wraps.
    assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);
    assign accept = in_valid && in_ready;
    // A window opens from IDLE, or straight from REPORT when the record is taken.
    assign clr    = start && ((state == IDLE) || ((state == REPORT) && res_ready));

    // Window control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state     <= REPORT;
                    busy      <= 1'b0;
                    res_valid <= 1'b1;
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            state    <= ACCUM;
                            cnt      <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the error distance of each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ed_q <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                ed_q <= ed;
            end
        end
    end

    // Stage 2: fold the captured distance into the window statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (clr) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (v1) begin
            sum_ed    <= sum_ed + SW'(ed_q);
            err_count <= err_count + CW'(|ed_q);
            if (ed_q > max_ed) begin
                max_ed <= ed_q;
            end
        end
    end

`ifdef AEM_BIAS_EN
    logic signed [N+1:0] diff;
    logic signed [N+1:0] diff_q;

    assign diff = $signed({1'b0, approx}) - $signed({1'b0, exact});

    // Stage 1 of the bias path: signed (approx - exact) per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
        end else if (accept) begin
            diff_q <= diff;
        end
    end

    // Stage 2 of the bias path: cleared and held exactly like sum_ed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_sum <= '0;
        end else if (clr) begin
            bias_sum <= '0;
        end else if (v1) begin
            bias_sum <= bias_sum + {{(SW-N-1){diff_q[N+1]}}, diff_q};
        end
    end
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - self-checking bench for approx_err_monitor (WINDOW=4)
module tb_approx_err_monitor;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int CW = 3;
    localparam int SW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic [N-1:0]  approx_sum = '0;
    logic          approx_fn = 1'b0;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [CW-1:0] err_count;
    logic [N:0]    max_ed;
    logic [SW-1:0] sum_ed;
`ifdef AEM_BIAS_EN
    logic signed [SW:0] bias_sum;
`endif

    int checks = 0;
    int errors = 0;

    approx_err_monitor #(.N(N), .WINDOW(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .approx_fn  (approx_fn),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .err_count  (err_count),
        .max_ed     (max_ed),
`ifdef AEM_BIAS_EN
        .sum_ed     (sum_ed),
        .bias_sum   (bias_sum)
`else
        .sum_ed     (sum_ed)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: window membership plus the list of sample errors.
    bit m_acc, m_drain, m_rv;
    int m_eds[$];
    int m_diffs[$];
    int m_ex, m_ap;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_acc = 0; m_drain = 0; m_rv = 0;
                m_eds.delete(); m_diffs.delete();
            end else if (m_rv) begin
                if (res_ready) begin
                    m_rv = 0;
                    if (start) begin
                        m_acc = 1; m_eds.delete(); m_diffs.delete();
                    end
                end
            end else if (m_drain) begin
                m_drain = 0; m_rv = 1;
            end else if (m_acc) begin
                if (in_valid) begin
                    m_ex = int'(a) + int'(b);
                    m_ap = int'(approx_fn) * 256 + int'(approx_sum);
                    m_eds.push_back(m_ex > m_ap ? m_ex - m_ap : m_ap - m_ex);
                    m_diffs.push_back(m_ap - m_ex);
                    if (m_eds.size() == W) begin
                        m_acc = 0; m_drain = 1;
                    end
                end
            end else if (start) begin
                m_acc = 1; m_eds.delete(); m_diffs.delete();
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare();
        int cnt, mx, sm, bs;
        cnt = 0; mx = 0; sm = 0; bs = 0;
        foreach (m_eds[i]) begin
            if (m_eds[i] != 0) cnt++;
            if (m_eds[i] > mx) mx = m_eds[i];
            sm += m_eds[i];
            bs += m_diffs[i];
        end
        check("in_ready", int'(in_ready), int'(m_acc));
        check("busy", int'(busy), int'(m_acc || m_drain));
        check("res_valid", int'(res_valid), int'(m_rv));
        if (m_rv || (!m_acc && !m_drain)) begin
            check("model_err_count", int'(err_count), cnt);
            check("model_max_ed", int'(max_ed), mx);
            check("model_sum_ed", int'(sum_ed), sm);
`ifdef AEM_BIAS_EN
            check("model_bias_sum", int'(bias_sum), bs);
`endif
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare();
        #1;
    endtask

    task automatic put(input int av, input int bv, input int apv);
        logic [N:0] ap;
        ap = (N+1)'(apv);
        a = N'(av); b = N'(bv);
        {approx_fn, approx_sum} = ap;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_rv();
        for (int i = 0; i < 20 && !res_valid; i++) cyc();
        check("rv_timeout", int'(res_valid), 1);
    endtask

    task automatic release_record();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("rv_falls", int'(res_valid), 0);
    endtask

    task automatic lit_record(input string tag, input int ec, input int mx, input int sm);
        check({tag, "_err_count"}, int'(err_count), ec);
        check({tag, "_max_ed"}, int'(max_ed), mx);
        check({tag, "_sum_ed"}, int'(sum_ed), sm);
    endtask

    initial begin
        #1;
        for (int i = 0; i < 3; i++) cyc();
        rst_n = 1'b1;
        cyc();

        // Reset mid-window after two samples.
        pulse_start();
        put(50, 1, 51);
        put(81, 18, 97);
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        lit_record("rst", 0, 0, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Window of exact samples.
        pulse_start();
        put(10, 20, 30);
        put(0, 0, 0);
        put(255, 255, 510);
        put(128, 7, 135);
        wait_rv();
        lit_record("exact", 0, 0, 0);
        release_record();
        cyc();

        // Mixed window with latency and backpressure.
        pulse_start();
        put(50, 1, 51);
        put(81, 18, 97);
        put(60, 81, 143);
        put(103, 97, 192);
        check("lat_drain_rv", int'(res_valid), 0);
        cyc();
        check("lat_report_rv", int'(res_valid), 1);
        lit_record("mixed", 3, 8, 12);
`ifdef AEM_BIAS_EN
        check("mixed_bias", int'(bias_sum), -8);
`endif
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            cyc();
            check("bp_rv", int'(res_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            lit_record("bp", 3, 8, 12);
        end
        in_valid = 1'b0;

        // Back-to-back window started with res_ready; includes carry-out error.
        res_ready = 1'b1;
        start = 1'b1;
        cyc();
        res_ready = 1'b0;
        start = 1'b0;
        check("b2b_rv", int'(res_valid), 0);
        check("b2b_in_ready", int'(in_ready), 1);
        put(255, 1, 0);
        put(10, 20, 30);
        put(1, 1, 3);
        put(200, 100, 300);
        wait_rv();
        lit_record("b2b", 2, 256, 257);
`ifdef AEM_BIAS_EN
        check("b2b_bias", int'(bias_sum), -255);
`endif
        release_record();
        cyc();
        check("hold_busy", int'(busy), 0);
        lit_record("hold", 2, 256, 257);

        // Mixed window again with gaps and stray start pulses.
        pulse_start();
        put(50, 1, 51);
        cyc();
        pulse_start();
        put(81, 18, 97);
        cyc(); cyc();
        put(60, 81, 143);
        pulse_start();
        cyc();
        put(103, 97, 192);
        wait_rv();
        lit_record("gaps", 3, 8, 12);
        release_record();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
